// File: rtl/wm8731_cfg_sequencer.sv
// WM8731 register-write sequencer: plays the power-up table through the I2C frame
// engine with retry/timeout handling, then serves single runtime register writes.
`timescale 1ns/1ps
module wm8731_cfg_sequencer #(
  parameter logic [7:0] DEV_ADDR   = 8'h34,
  parameter int         MAX_RETRY  = 3,
  parameter int         GAP_CYCLES = 4,
  parameter int         TIMEOUT    = 2048
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_req,
  input  logic [15:0] i_req_data,
  output logic        o_req_ack,
  output logic        o_tx_start,
  output logic [23:0] o_tx_data,
  input  logic        i_tx_done,
  input  logic        i_tx_nack,
  output logic        o_busy,
  output logic        o_init_done,
  output logic        o_error
);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [7:0]    GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, INIT_ISSUE, INIT_WAIT, INIT_GAP, READY,
    REQ_ISSUE, REQ_WAIT, REQ_GAP, ERROR
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      idx, idx_nxt;
  logic [RW-1:0]   retry, retry_nxt;
  logic [7:0]      gap_cnt, gap_nxt;
  logic [TW-1:0]   to_cnt, to_nxt;
  logic [23:0]     tx_data, data_nxt;
  logic            ack_q, ack_nxt;

  function automatic logic [15:0] init_word(input logic [2:0] i);
    case (i)
      3'd0:    init_word = 16'h1E00;
      3'd1:    init_word = 16'h0815;
      3'd2:    init_word = 16'h0A00;
      3'd3:    init_word = 16'h0C00;
      3'd4:    init_word = 16'h0E42;
      3'd5:    init_word = 16'h1019;
      3'd6:    init_word = 16'h1201;
      default: init_word = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      idx     <= '0;
      retry   <= '0;
      gap_cnt <= '0;
      to_cnt  <= '0;
      tx_data <= '0;
      ack_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      retry   <= retry_nxt;
      gap_cnt <= gap_nxt;
      to_cnt  <= to_nxt;
      tx_data <= data_nxt;
      ack_q   <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    retry_nxt = retry;
    gap_nxt   = gap_cnt;
    to_nxt    = to_cnt;
    data_nxt  = tx_data;
    ack_nxt   = 1'b0;
    case (state)
      IDLE, ERROR: begin
        if (i_start) begin
          idx_nxt   = '0;
          retry_nxt = '0;
          data_nxt  = {DEV_ADDR, init_word(3'd0)};
          state_nxt = INIT_ISSUE;
        end
      end
      INIT_ISSUE: begin
        to_nxt    = '0;
        state_nxt = INIT_WAIT;
      end
      REQ_ISSUE: begin
        to_nxt    = '0;
        state_nxt = REQ_WAIT;
      end
      INIT_WAIT, REQ_WAIT: begin
        if (i_tx_done || (to_cnt == TO_LAST)) begin
          gap_nxt = '0;
          if (i_tx_done && !i_tx_nack) begin
            retry_nxt = '0;
            if (state == INIT_WAIT) idx_nxt = idx + 3'd1;
            state_nxt = (state == INIT_WAIT) ? INIT_GAP : REQ_GAP;
          end else if (retry != RETRY_MAX) begin
            retry_nxt = retry + RW'(1);
            state_nxt = (state == INIT_WAIT) ? INIT_GAP : REQ_GAP;
          end else begin
            state_nxt = ERROR;
          end
        end else if (to_cnt != TO_LAST) begin
          to_nxt = to_cnt + TW'(1);
        end
      end
      INIT_GAP: begin
        // idx only reaches 7 on a success, so any other value means issue idx (new or retried)
        if (gap_cnt == GAP_LAST) begin
          if (idx == 3'd7) begin
            state_nxt = READY;
          end else begin
            data_nxt  = {DEV_ADDR, init_word(idx)};
            state_nxt = INIT_ISSUE;
          end
        end else begin
          gap_nxt = gap_cnt + 8'd1;
        end
      end
      READY: begin
        // the ack cycle is committed: the accepted request goes out next
        if (ack_q) begin
          state_nxt = REQ_ISSUE;
        end else if (i_start) begin
          idx_nxt   = '0;
          retry_nxt = '0;
          data_nxt  = {DEV_ADDR, init_word(3'd0)};
          state_nxt = INIT_ISSUE;
        end else if (i_req) begin
          ack_nxt  = 1'b1;
          data_nxt = {DEV_ADDR, i_req_data};
        end
      end
      REQ_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = (retry != '0) ? REQ_ISSUE : READY;
        end else begin
          gap_nxt = gap_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_tx_start  = (state == INIT_ISSUE) || (state == REQ_ISSUE);
  assign o_tx_data   = tx_data;
  assign o_req_ack   = ack_q;
  assign o_busy      = (state != IDLE) && (state != READY) && (state != ERROR);
  assign o_init_done = (state == READY);
  assign o_error     = (state == ERROR);

endmodule

// File: tb/tb_wm8731_cfg_sequencer.sv
// Randomized bench for wm8731_cfg_sequencer: the bench plays the I2C engine and
// predicts every frame (word and start cycle) from the sequencing rules.
`timescale 1ns/1ps
module tb_wm8731_cfg_sequencer;
  localparam int         GAP  = 4;
  localparam int         TMO  = 2048;
  localparam int         MAXR = 3;
  localparam logic [7:0] DEV  = 8'h34;

  logic        clk = 1'b0;
  logic        rst, start, req, tx_done, tx_nack;
  logic [15:0] req_data;
  logic        req_ack, tx_start, busy, init_done, error;
  logic [23:0] tx_data;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int ack_cnt = 0;
  logic [15:0] init_tbl [7];

  wm8731_cfg_sequencer #(
    .DEV_ADDR(DEV), .MAX_RETRY(MAXR), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_req(req), .i_req_data(req_data),
    .o_req_ack(req_ack), .o_tx_start(tx_start), .o_tx_data(tx_data),
    .i_tx_done(tx_done), .i_tx_nack(tx_nack), .o_busy(busy),
    .o_init_done(init_done), .o_error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (req_ack === 1'b1) ack_cnt <= ack_cnt + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_start(input int bound, output int s, output bit seen);
    seen = 1'b0;
    s = cyc;
    for (int i = 0; i < bound; i++) begin
      if (tx_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    s = cyc;
  endtask

  // One engine transaction; lat<=0 means the engine never answers (timeout).
  task automatic frame(input int exp_s, input logic [23:0] exp_d, input int lat,
                       input bit nack, output int d);
    int s;
    bit seen;
    wait_start(TMO + 200, s, seen);
    chk("start_seen", 32'(seen), 32'd1);
    chk("start_cyc", s, exp_s);
    chk("tx_data", 32'(tx_data), 32'(exp_d));
    chk("busy_issue", 32'(busy), 32'd1);
    if (lat > 0) begin
      repeat (lat) @(negedge clk);
      chk("tx_data_hold", 32'(tx_data), 32'(exp_d));
      tx_done = 1'b1;
      tx_nack = nack;
      d = cyc;
      @(negedge clk);
      tx_done = 1'b0;
      tx_nack = 1'($urandom);
    end else begin
      d = s + TMO;
      wait_until(d + 1);
    end
  endtask

  task automatic expect_ready(input int d);
    wait_until(d + GAP);
    chk("ready_early", 32'(init_done), 32'd0);
    chk("busy_gap", 32'(busy), 32'd1);
    @(negedge clk);
    chk("init_done", 32'(init_done), 32'd1);
    chk("busy_ready", 32'(busy), 32'd0);
    chk("error_ready", 32'(error), 32'd0);
  endtask

  task automatic expect_error();
    chk("error", 32'(error), 32'd1);
    chk("busy_error", 32'(busy), 32'd0);
    chk("init_done_error", 32'(init_done), 32'd0);
  endtask

  task automatic kick(output int c0);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Reference: walk the table; nf[i] = failing attempts at index i before an ACK.
  task automatic run_init(input int first_exp, input int plan[7], input bit use_to,
                          input int fixed_lat, output bit err);
    int nf[7];
    int idx, retry, exp_s, d, lat;
    bit fail;
    nf = plan;
    idx = 0; retry = 0; exp_s = first_exp; err = 1'b0; d = cyc;
    while (idx < 7) begin
      fail = (nf[idx] > 0);
      lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 40));
      frame(exp_s, {DEV, init_tbl[idx]}, (fail && use_to) ? 0 : lat, fail, d);
      exp_s = d + 1 + GAP;
      if (!fail) begin
        idx++;
        retry = 0;
      end else begin
        nf[idx]--;
        if (retry == MAXR) begin
          err = 1'b1;
          break;
        end
        retry++;
      end
    end
    if (err) expect_error();
    else expect_ready(d);
  endtask

  task automatic do_req(input logic [15:0] data, input int nfail, output bit err);
    int r, d, retry, a0, exp_s, nf;
    bit fail;
    a0 = ack_cnt;
    nf = nfail;
    req = 1'b1;
    req_data = data;
    r = cyc;
    @(negedge clk);
    chk("req_ack", 32'(req_ack), 32'd1);
    req = 1'b0;
    req_data = 16'($urandom);
    exp_s = r + 2; retry = 0; err = 1'b0; d = cyc;
    forever begin
      fail = (nf > 0);
      frame(exp_s, {DEV, data}, int'($urandom_range(1, 40)), fail, d);
      exp_s = d + 1 + GAP;
      if (!fail) break;
      nf--;
      if (retry == MAXR) begin
        err = 1'b1;
        break;
      end
      retry++;
    end
    if (err) expect_error();
    else expect_ready(d);
    chk("ack_once", ack_cnt - a0, 32'd1);
  endtask

  initial begin
    int c0, plan[7], a0, n;
    bit err;
    logic [15:0] rd;
    init_tbl = '{16'h1E00, 16'h0815, 16'h0A00, 16'h0C00, 16'h0E42, 16'h1019, 16'h1201};
    rst = 1'b1; start = 1'b0; req = 1'b0; req_data = '0; tx_done = 1'b0; tx_nack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_ack", 32'(req_ack), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_no_start", 32'(tx_start), 32'd0);

    // clean init at L=30 with a request pending throughout
    req = 1'b1; req_data = 16'h0479;
    plan = '{0, 0, 0, 0, 0, 0, 0};
    a0 = ack_cnt;
    kick(c0);
    run_init(c0 + 1, plan, 1'b0, 30, err);
    chk("init_latency", cyc - c0, 7 * (1 + 30 + GAP) + 1);
    chk("no_ack_during_init", ack_cnt, a0);
    do_req(16'h0479, 0, err);

    // done outside WAIT is ignored
    tx_done = 1'b1; tx_nack = 1'($urandom);
    @(negedge clk);
    tx_done = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx_start === 1'b1) n++;
    end
    chk("stray_done_starts", n, 0);
    chk("stray_done_ready", 32'(init_done), 32'd1);

    // NACK on index 3 twice, restart issued from READY
    plan = '{0, 0, 0, 2, 0, 0, 0};
    kick(c0);
    run_init(c0 + 1, plan, 1'b0, 0, err);
    chk("nack3_err", 32'(err), 32'd0);

    // NACK on index 0 four times -> ERROR, then restart
    plan = '{4, 0, 0, 0, 0, 0, 0};
    kick(c0);
    run_init(c0 + 1, plan, 1'b0, 0, err);
    chk("nack0_err", 32'(err), 32'd1);
    plan = '{0, 0, 0, 0, 0, 0, 0};
    kick(c0);
    run_init(c0 + 1, plan, 1'b0, 0, err);

    // engine never answers on index 0 -> four timeouts then ERROR
    plan = '{4, 0, 0, 0, 0, 0, 0};
    kick(c0);
    run_init(c0 + 1, plan, 1'b1, 0, err);
    chk("timeout_err", 32'(err), 32'd1);
    plan = '{0, 0, 0, 0, 0, 0, 0};
    kick(c0);
    run_init(c0 + 1, plan, 1'b0, 0, err);

    // start and req together in READY: restart wins, request served afterwards
    rd = 16'($urandom);
    a0 = ack_cnt;
    start = 1'b1; req = 1'b1; req_data = rd; c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("start_req_no_ack", 32'(req_ack), 32'd0);
    run_init(c0 + 1, plan, 1'b0, 0, err);
    chk("start_req_no_ack_init", ack_cnt, a0);
    do_req(rd, 0, err);

    // randomized init failures and runtime writes
    for (int it = 0; it < 5; it++) begin
      plan = '{0, 0, 0, 0, 0, 0, 0};
      plan[$urandom_range(0, 6)] = int'($urandom_range(0, 4));
      plan[$urandom_range(0, 6)] = int'($urandom_range(0, 2));
      kick(c0);
      run_init(c0 + 1, plan, 1'b0, 0, err);
      if (!err) begin
        for (int k = 0; k < 3; k++) begin
          do_req(16'($urandom), int'($urandom_range(0, 4)), err);
          if (err) break;
        end
      end
    end

    // asynchronous reset in the middle of a WAIT
    kick(c0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_tx_start", 32'(tx_start), 32'd0);
    chk("midrst_tx_data", 32'(tx_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_init_done", 32'(init_done), 32'd0);
    chk("midrst_error", 32'(error), 32'd0);
    chk("midrst_ack", 32'(req_ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_start === 1'b1 || busy === 1'b1) n++;
    end
    chk("post_rst_idle", n, 0);
    plan = '{0, 0, 0, 0, 0, 0, 0};
    kick(c0);
    run_init(c0 + 1, plan, 1'b0, 0, err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wm8731_cfg_sequencer.md
# wm8731_cfg_sequencer

Sequences all register writes to the WM8731 audio codec through the shared I2C frame engine (one 24-bit frame per handshake). On `i_start` it plays a fixed 7-entry power-up table, retrying NACKed or timed-out frames. After that it serves single runtime register writes, such as volume or mute changes, from the audio control path. It is the only master of the I2C engine's start/data inputs.

## Interface

- `DEV_ADDR`, 8'h34: I2C device byte (7-bit address 0x1A, R/W=0)
- `MAX_RETRY`, 3: re-issues allowed per frame after the first attempt
- `GAP_CYCLES`, 4: idle cycles between the end of one frame and the start of the next (range 1..255)
- `TIMEOUT`, 2048: cycles in WAIT without `i_tx_done` before the frame counts as failed
- `i_clk`  in  1  system clock; all logic on the rising edge
- `i_rst`  in  1  asynchronous, active-high reset
- `i_start`  in  1  level-sampled; begins or restarts the init sequence
- `i_req`  in  1  runtime write request; held high until acknowledged
- `i_req_data`  in  16  {reg_addr[6:0], reg_data[8:0]}; must be stable while `i_req` is high
- `o_req_ack`  out  1  one-cycle pulse when the request is accepted
- `o_tx_start`  out  1  one-cycle start pulse to the I2C engine
- `o_tx_data`  out  24  {DEV_ADDR, reg word}; stable from `o_tx_start` until `i_tx_done`
- `i_tx_done`  in  1  one-cycle pulse; the engine has finished the frame
- `i_tx_nack`  in  1  qualified by `i_tx_done`; some byte was NACKed
- `o_busy`  out  1  high in every state except IDLE, READY and ERROR
- `o_init_done`  out  1  high while in READY
- `o_error`  out  1  high while in ERROR

## Operation

- Init table, in index order: 0x1E00 (reset), 0x0815, 0x0A00, 0x0C00, 0x0E42, 0x1019, 0x1201 (active).
- States: IDLE, INIT_ISSUE, INIT_WAIT, INIT_GAP, READY, REQ_ISSUE, REQ_WAIT, REQ_GAP, ERROR.
- IDLE: on `i_start`, clear `idx` and `retry`, then go to INIT_ISSUE.
- `*_ISSUE`: lasts exactly one cycle with `o_tx_start`=1 and `o_tx_data` loaded. Clears the timeout counter, then goes to `*_WAIT`.
- `*_WAIT`, when `i_tx_done` arrives or the timeout counter reaches TIMEOUT-1:
  - Success (done with `i_tx_nack`=0): `retry`=0; in INIT also increment `idx`. Go to `*_GAP`.
  - Failure with `retry`<MAX_RETRY: increment `retry`, go to `*_GAP`, then re-issue the same word.
  - Failure with `retry`=MAX_RETRY: go to ERROR.
- INIT_GAP: counts GAP_CYCLES, then goes to READY if `idx`=7, otherwise to INIT_ISSUE.
- READY:
  - `i_start` has priority: restart the init sequence (go to INIT_ISSUE with `idx`=0). No ack is given that cycle.
  - Otherwise `i_req`: latch `i_req_data`, pulse `o_req_ack`, go to REQ_ISSUE.
- REQ_GAP: counts GAP_CYCLES, then goes to READY.
- ERROR: holds until `i_start`, which restarts init from `idx`=0 and clears `o_error`.
- `i_start` in any busy state is ignored.
- `i_req` outside READY is left pending and is never acknowledged there.
- `i_tx_done` outside `*_WAIT` is ignored.
- Counters:
  - `idx` is 3-bit.
  - `retry` is sized to hold MAX_RETRY.
  - The gap and timeout counters saturate and never wrap.

## Timing

- Reset values: all outputs 0; `o_tx_data`=0; state IDLE.
- Reset mid-frame aborts immediately. After release the block sits in IDLE with no `o_tx_start` until `i_start`.
- `i_start` sampled high at edge t (IDLE): `o_tx_start`=1 during cycle t+1.
- `i_tx_done` at edge t: next `o_tx_start` at cycle t+1+GAP_CYCLES.
- `o_init_done` rises GAP_CYCLES+1 cycles after the 7th successful done.
- `o_req_ack` and `o_tx_start` for a request are on consecutive cycles: ack at t+1, start at t+2, where t is the edge that samples `i_req` in READY.
- Best-case init, with an engine latency of L cycles from start to done: 7·(1+L+GAP_CYCLES)+1 cycles.

## Test plan

- Reset, then `i_start`; engine returns done at L=30 with no NACK. Required: 7 `o_tx_start` pulses carrying 0x341E00, 0x340815, 0x340A00, 0x340C00, 0x340E42, 0x341019, 0x341201, followed by `o_init_done`=1 and `o_busy`=0.
- NACK on index 3 twice, then ACK. Required: 0x340C00 issued 3 times, sequence completes, `o_error`=0.
- NACK on index 0 four times. Required: 4 issues of 0x341E00, then `o_error`=1 and `o_busy`=0; a subsequent `i_start` restarts from 0x341E00.
- Engine never returns done. Required: re-issue each TIMEOUT cycles, ERROR after 4 attempts.
- In READY, `i_req`=1 with data 0x0479. Required: `o_req_ack` pulse, then `o_tx_data`=0x340479. Also assert `i_req` during init: no ack until READY.
- `i_start` and `i_req` together in READY: init restarts, no ack. Also assert `i_rst` mid-WAIT: all outputs 0 and state IDLE.
